// File: rtl/escalonador_escrita_reg_if.sv
// Writeback scheduler bus: the two writeback requesters, the issue-stage
// reservation/hazard lookup and the register file write controls.
interface escalonador_escrita_reg_if #(
   parameter int LARG_END  = 6,
   parameter int LARG_DADO = 32
);
   // ULA writeback requester
   logic                 req_ula;
   logic [LARG_END-1:0]  end_ula;
   logic [LARG_DADO-1:0] dado_ula;
   logic                 ack_ula;

   // Memory (load) writeback requester
   logic                 req_mem;
   logic [LARG_END-1:0]  end_mem;
   logic [LARG_DADO-1:0] dado_mem;
   logic                 ack_mem;

   // Issue stage: destination reservation and RAW hazard lookup
   logic                 reserva;
   logic [LARG_END-1:0]  end_reserva;
   logic [LARG_END-1:0]  RLe1;
   logic [LARG_END-1:0]  RLe2;
   logic                 pendente1;
   logic                 pendente2;

   // Register file write port and statistics
   logic [LARG_END-1:0]  REscrita;
   logic [LARG_DADO-1:0] DadoEscrita;
   logic                 EscreveReg;
   logic [15:0]          conflitos;

   // Environment side: requesters, issue stage and register file
   modport master (
      output req_ula, end_ula, dado_ula,
      input  ack_ula,
      output req_mem, end_mem, dado_mem,
      input  ack_mem,
      output reserva, end_reserva, RLe1, RLe2,
      input  pendente1, pendente2,
      input  REscrita, DadoEscrita, EscreveReg, conflitos
   );

   // Scheduler side
   modport slave (
      input  req_ula, end_ula, dado_ula,
      output ack_ula,
      input  req_mem, end_mem, dado_mem,
      output ack_mem,
      input  reserva, end_reserva, RLe1, RLe2,
      output pendente1, pendente2,
      output REscrita, DadoEscrita, EscreveReg, conflitos
   );
endinterface

// File: rtl/escalonador_escrita_reg.sv
// Write-port scheduler for the 64x32 register file.
// Round-robin arbitration between the ULA and memory writeback requesters,
// registered register-file write controls, a pending-write scoreboard used
// by the issue stage for RAW stalls, and protection of two fixed registers.
module escalonador_escrita_reg #(
   parameter int NUM_REG    = 64,
   parameter int LARG_END   = 6,
   parameter int LARG_DADO  = 32,
   parameter int REG_FIXO_A = 62,
   parameter int REG_FIXO_B = 61
) (
   input  logic clock,
   input  logic reset,
   escalonador_escrita_reg_if.slave bus
);

   // Which requester won the most recent grant; the other one wins a tie.
   typedef enum logic {
      ULT_ULA = 1'b0,
      ULT_MEM = 1'b1
   } ultimo_t;

   ultimo_t              ultimo_q, ultimo_d;
   logic [NUM_REG-1:0]   placar_q, placar_d;
   logic [LARG_END-1:0]  rescrita_q, rescrita_d;
   logic [LARG_DADO-1:0] dado_q, dado_d;
   logic                 escreve_q, escreve_d;
   logic [15:0]          conflitos_q, conflitos_d;

   logic                 concede_ula;
   logic                 concede_mem;
   logic                 concede;
   logic                 contencao;
   logic [LARG_END-1:0]  end_concedido;
   logic [LARG_DADO-1:0] dado_concedido;
   logic                 reserva_valida;
   logic [NUM_REG-1:0]   limpa_bit;
   logic [NUM_REG-1:0]   marca_bit;

   // Writes to the fixed registers are swallowed and they are never reserved.
   function automatic logic eh_fixo(input logic [LARG_END-1:0] endereco);
      return (endereco == LARG_END'(REG_FIXO_A)) ||
             (endereco == LARG_END'(REG_FIXO_B));
   endfunction

   assign contencao = bus.req_ula && bus.req_mem;

   // Round-robin grant; no grant at all while reset is asserted.
   always_comb begin
      concede_ula = 1'b0;
      concede_mem = 1'b0;
      if (!reset) begin
         if (contencao) begin
            if (ultimo_q == ULT_MEM) begin
               concede_ula = 1'b1;
            end else begin
               concede_mem = 1'b1;
            end
         end else begin
            concede_ula = bus.req_ula;
            concede_mem = bus.req_mem;
         end
      end
   end

   assign concede = concede_ula || concede_mem;

   // Mux the winning requester's address and data onto the write path.
   always_comb begin
      end_concedido  = bus.end_mem;
      dado_concedido = bus.dado_mem;
      if (concede_ula) begin
         end_concedido  = bus.end_ula;
         dado_concedido = bus.dado_ula;
      end
   end

   assign bus.ack_ula = concede_ula;
   assign bus.ack_mem = concede_mem;

   // Arbitration history and write-port next state.
   always_comb begin
      ultimo_d   = ultimo_q;
      rescrita_d = rescrita_q;
      dado_d     = dado_q;
      escreve_d  = 1'b0;
      if (concede) begin
         ultimo_d   = concede_mem ? ULT_MEM : ULT_ULA;
         rescrita_d = end_concedido;
         dado_d     = dado_concedido;
         // The grant is consumed even when the write itself is suppressed.
         escreve_d  = !eh_fixo(end_concedido);
      end
   end

   assign reserva_valida = bus.reserva && !eh_fixo(bus.end_reserva);

   // Per-register clear (write granted) and set (new reservation) decode.
   generate
      for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_placar
         assign limpa_bit[gi] = concede && (end_concedido == LARG_END'(gi));
         assign marca_bit[gi] = reserva_valida && (bus.end_reserva == LARG_END'(gi));
      end
   endgenerate

   // A reservation on the same edge as the write it would clear is younger,
   // so the set is applied after the clear.
   always_comb begin
      placar_d = (placar_q & ~limpa_bit) | marca_bit;
   end

   // Saturating count of cycles with both requesters active.
   always_comb begin
      conflitos_d = conflitos_q;
      if (contencao && (conflitos_q != 16'hFFFF)) begin
         conflitos_d = conflitos_q + 16'd1;
      end
   end

   // State registers; reset drops any in-flight write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ultimo_q    <= ULT_MEM;
         placar_q    <= '0;
         rescrita_q  <= '0;
         dado_q      <= '0;
         escreve_q   <= 1'b0;
         conflitos_q <= '0;
      end else begin
         ultimo_q    <= ultimo_d;
         placar_q    <= placar_d;
         rescrita_q  <= rescrita_d;
         dado_q      <= dado_d;
         escreve_q   <= escreve_d;
         conflitos_q <= conflitos_d;
      end
   end

   // A read address is hazardous while reserved, and also during the cycle
   // the write is presented to the register file but not yet stored.
   always_comb begin
      bus.pendente1 = placar_q[bus.RLe1] || (escreve_q && (rescrita_q == bus.RLe1));
      bus.pendente2 = placar_q[bus.RLe2] || (escreve_q && (rescrita_q == bus.RLe2));
   end

   assign bus.REscrita    = rescrita_q;
   assign bus.DadoEscrita = dado_q;
   assign bus.EscreveReg  = escreve_q;
   assign bus.conflitos   = conflitos_q;

endmodule
